// File: rtl/nios2_onchip_memory_dp.sv
// True dual-port Avalon-MM RAM (s1, s2) with write-first cross-port forwarding,
// per-byte collision merge (s1 wins), READ_LATENCY-deep read pipe and optional zero-fill sweep.
module nios2_onchip_memory_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b0,
    parameter     INIT_FILE      = "nios2_onchip_memory.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reset_req,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,

    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest,

    output logic                  clear_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic                run_ok;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   addr [2];
    logic [BE_W-1:0]     be   [2];
    logic [DATA_W-1:0]   wdat [2];
    logic [DATA_W-1:0]   post [2];
    logic [DATA_W-1:0]   rdat [2];
    logic [1:0]          cs, rd_req, wr_req, acc, wr_en, rd_en, rvld;

    assign addr[0] = s1_address;
    assign addr[1] = s2_address;
    assign be[0]   = s1_byteenable;
    assign be[1]   = s2_byteenable;
    assign wdat[0] = s1_writedata;
    assign wdat[1] = s2_writedata;
    assign cs      = {s2_chipselect, s1_chipselect};
    assign rd_req  = {s2_read, s1_read};
    assign wr_req  = {s2_write, s1_write};

    // Overlay the enabled bytes of one port's write onto a word.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] base,
        input logic              hit,
        input logic [BE_W-1:0]   bmask,
        input logic [DATA_W-1:0] data
    );
        merge = base;
        for (int k = 0; k < BE_W; k++) begin
            if (hit && bmask[k]) begin
                merge[8*k +: 8] = data[8*k +: 8];
            end
        end
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) begin
                state <= ST_RUN;
            end
        end
    end

    assign clear_busy     = (state == ST_CLEAR);
    assign run_ok         = reset_n && (state == ST_RUN) && !reset_req;
    assign s1_waitrequest = !run_ok;
    assign s2_waitrequest = !run_ok;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [READ_LATENCY-1:0] pv;
        logic [DATA_W-1:0]       pd [READ_LATENCY];

        assign acc[p]   = run_ok && cs[p] && (rd_req[p] || wr_req[p]);
        assign wr_en[p] = acc[p] && wr_req[p];
        assign rd_en[p] = acc[p] && rd_req[p] && !wr_req[p];

        // Word at this port's address after this cycle's writes; s2 applied first so s1 wins per byte.
        assign post[p] = merge(merge(mem[addr[p]], wr_en[1] && (addr[1] == addr[p]), be[1], wdat[1]),
                               wr_en[0] && (addr[0] == addr[p]), be[0], wdat[0]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pv <= '0;
                for (int i = 0; i < READ_LATENCY; i++) begin
                    pd[i] <= '0;
                end
            end else begin
                pv[0] <= rd_en[p];
                if (rd_en[p]) begin
                    pd[0] <= post[p];
                end
                // Data stages only load on valid so readdata holds between pulses.
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pv[i] <= pv[i-1];
                    if (pv[i-1]) begin
                        pd[i] <= pd[i-1];
                    end
                end
            end
        end

        assign rvld[p] = pv[READ_LATENCY-1];
        assign rdat[p] = pd[READ_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_en[0]) begin
                mem[addr[0]] <= post[0];
            end
            if (wr_en[1]) begin
                mem[addr[1]] <= post[1];
            end
        end
    end

    assign s1_readdata      = rdat[0];
    assign s1_readdatavalid = rvld[0];
    assign s2_readdata      = rdat[1];
    assign s2_readdatavalid = rvld[1];

endmodule
